// File: rtl/spi_slave_sck_sampler_if.sv
// SPI pad, mode select and word handshake bundle for spi_slave_sck_sampler.
// slave modport is the sampler's view; master modport is the pad/host view.
interface spi_slave_sck_sampler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cpol;
  logic                  cpha;
  logic                  spi_sck;
  logic                  spi_csn;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  sample_strobe;
  logic                  shift_strobe;
  logic                  frame_start;
  logic                  frame_end;
  logic                  rx_abort;
  logic                  busy;

  modport slave (
    input  cpol, cpha, spi_sck, spi_csn, spi_mosi, tx_data,
    output spi_miso, spi_miso_oe, tx_load, rx_data, rx_valid, sample_strobe,
           shift_strobe, frame_start, frame_end, rx_abort, busy
  );

  modport master (
    output cpol, cpha, spi_sck, spi_csn, spi_mosi, tx_data,
    input  spi_miso, spi_miso_oe, tx_load, rx_data, rx_valid, sample_strobe,
           shift_strobe, frame_start, frame_end, rx_abort, busy
  );
endinterface

// File: rtl/spi_slave_sck_sampler.sv
// SPI slave SCK front end: oversamples SCK/CSN/MOSI in the clk domain and
// derives sample/shift strobes for all four SPI modes, with a word shifter.
// Optional: define SPI_SLAVE_SCK_DEGLITCH_EN to add a 2-sample SCK glitch
// filter (one extra clk of edge latency; clk must then be >= 6x SCK).
module spi_slave_sck_sampler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_slave_sck_sampler_if.slave   bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StActive} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]   csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
  logic                     sck_dly_q, sck_dly_d;
  logic                     csn_dly_q, csn_dly_d;
  logic                     cpol_q, cpol_d;
  logic                     cpha_q, cpha_d;
  logic [CntW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]    tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     tx_load_q, tx_load_d;
  logic                     sample_q, sample_d;
  logic                     shift_q, shift_d;
  logic                     frame_start_q, frame_start_d;
  logic                     frame_end_q, frame_end_d;
  logic                     rx_abort_q, rx_abort_d;

  logic sck_s, csn_s, mosi_s, sck_f;
  logic sck_edge, lead_edge, trail_edge, do_sample, do_shift;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_SCK_DEGLITCH_EN
  logic sck_prev_q, sck_prev_d;

  // Filtered SCK follows sck_s only once two consecutive samples agree.
  always_comb begin
    sck_prev_d = sck_s;
    sck_f      = (sck_s == sck_prev_q) ? sck_s : sck_dly_q;
  end

  // Previous synchronised SCK sample for the glitch filter.
  always_ff @(posedge clk) begin
    if (rst) sck_prev_q <= 1'b0;
    else     sck_prev_q <= sck_prev_d;
  end
`else
  // Unfiltered: edges are taken straight from the synchroniser output.
  always_comb sck_f = sck_s;
`endif

  // Synchronisers, edge detection, framing FSM and shifters (next state).
  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    csn_sync_d    = {csn_sync_q[SYNC_STAGES-2:0], bus.spi_csn};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    sck_dly_d     = sck_f;
    csn_dly_d     = csn_s;
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_load_d     = 1'b0;
    sample_d      = 1'b0;
    shift_d       = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    rx_abort_d    = 1'b0;

    // Leading edge leaves the latched idle level, trailing edge returns to it.
    sck_edge   = (sck_f != sck_dly_q);
    lead_edge  = sck_edge && (sck_dly_q == cpol_q);
    trail_edge = sck_edge && (sck_f == cpol_q);
    do_sample  = cpha_q ? trail_edge : lead_edge;
    do_shift   = cpha_q ? lead_edge : trail_edge;

    unique case (state_q)
      StIdle: begin
        if (csn_dly_q && !csn_s) begin
          state_d       = StActive;
          frame_start_d = 1'b1;
          cpol_d        = bus.cpol;
          cpha_d        = bus.cpha;
          bit_cnt_d     = '0;
          rx_shift_d    = '0;
          // CPHA=0 masters sample on the first edge, so the MSB must already be out.
          if (!bus.cpha) begin
            tx_shift_d = bus.tx_data;
            tx_load_d  = 1'b1;
          end
        end
      end
      StActive: begin
        if (csn_s) begin
          // Frame end wins over any SCK edge seen in the same cycle.
          state_d     = StIdle;
          frame_end_d = 1'b1;
          rx_abort_d  = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
        end else begin
          if (do_sample) begin
            sample_d   = 1'b1;
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LastBit) begin
              rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (do_shift) begin
            shift_d = 1'b1;
            if (bit_cnt_q == '0) begin
              tx_shift_d = bus.tx_data;
              tx_load_d  = 1'b1;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sck_sync_q    <= '0;
      csn_sync_q    <= '1;
      mosi_sync_q   <= '0;
      sck_dly_q     <= 1'b0;
      csn_dly_q     <= 1'b1;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      sample_q      <= 1'b0;
      shift_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      rx_abort_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      csn_sync_q    <= csn_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_dly_q     <= sck_dly_d;
      csn_dly_q     <= csn_dly_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_load_q     <= tx_load_d;
      sample_q      <= sample_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      rx_abort_q    <= rx_abort_d;
    end
  end

  assign bus.busy          = (state_q == StActive);
  assign bus.spi_miso_oe   = (state_q == StActive);
  assign bus.spi_miso      = tx_shift_q[DATA_WIDTH-1];
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.tx_load       = tx_load_q;
  assign bus.sample_strobe = sample_q;
  assign bus.shift_strobe  = shift_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.frame_end     = frame_end_q;
  assign bus.rx_abort      = rx_abort_q;

endmodule

// File: tb/tb_spi_slave_sck_sampler.sv
// Directed bench for spi_slave_sck_sampler: the bench plays SPI master with
// SCK at 1/8 of clk and checks strobes, shifters and framing per scenario.
module tb_spi_slave_sck_sampler;
  localparam int Half = 4;

  logic clk;
  logic rst;
  int   chk  = 0;
  int   pass = 0;

  // Event counters kept by the monitor; tests compare deltas.
  int   n_rxv = 0, n_samp = 0, n_samp_hi = 0, n_txload = 0, n_fs = 0;
  int   n_fe = 0, n_abort = 0, n_fe_abort = 0;
  logic [7:0] rx_hist [0:63];

  spi_slave_sck_sampler_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_sck_sampler #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_hist[n_rxv % 64] = bus.rx_data;
      n_rxv++;
    end
    if (bus.sample_strobe === 1'b1) begin
      n_samp++;
      if (bus.spi_sck === 1'b1) n_samp_hi++;
    end
    if (bus.tx_load === 1'b1) n_txload++;
    if (bus.frame_start === 1'b1) n_fs++;
    if (bus.frame_end === 1'b1) n_fe++;
    if (bus.rx_abort === 1'b1) n_abort++;
    if (bus.frame_end === 1'b1 && bus.rx_abort === 1'b1) n_fe_abort++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic pol, input logic pha);
    bus.cpol    = pol;
    bus.cpha    = pha;
    bus.spi_sck = pol;
    wait_clk(4);
    bus.spi_csn = 1'b0;
    wait_clk(Half);
  endtask

  task automatic frame_finish();
    wait_clk(Half);
    bus.spi_csn = 1'b1;
    wait_clk(6);
  endtask

  // Master side of n bit periods, MSB first; returns captured MISO bits.
  task automatic spi_bits(input logic pol, input logic pha, input int n,
                          input logic [31:0] mosi_w, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!pha) begin
        bus.spi_mosi = mosi_w[i];
        wait_clk(Half);
        bus.spi_sck = ~pol;
        miso_w = {miso_w[30:0], bus.spi_miso};
        wait_clk(Half);
        bus.spi_sck = pol;
      end else begin
        bus.spi_sck  = ~pol;
        bus.spi_mosi = mosi_w[i];
        wait_clk(Half);
        bus.spi_sck = pol;
        miso_w = {miso_w[30:0], bus.spi_miso};
        wait_clk(Half);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.spi_csn = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.tx_data = 8'h00;
    wait_clk(3);
    chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass++;
    chk++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", bus.spi_miso_oe); else pass++;
    chk++; if (bus.spi_miso !== 1'b0) $display("FAIL rst_miso: got %b want 0", bus.spi_miso); else pass++;
    chk++; if (bus.rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h want 00", bus.rx_data); else pass++;
    chk++; if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); else pass++;
    chk++; if (bus.tx_load !== 1'b0) $display("FAIL rst_tx_load: got %b want 0", bus.tx_load); else pass++;
    rst = 1'b0;
    wait_clk(4);
    chk++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else pass++;
  endtask

  task automatic test_mode0();
    logic [31:0] m;
    int rxv0 = n_rxv, tl0 = n_txload, s0 = n_samp, h0 = n_samp_hi, fs0 = n_fs;
    bus.tx_data = 8'hA5;
    frame_begin(1'b0, 1'b0);
    chk++; if (n_fs - fs0 !== 1) $display("FAIL m0_frame_start: got %0d want 1", n_fs - fs0); else pass++;
    chk++; if (n_txload - tl0 !== 1) $display("FAIL m0_tx_load_at_start: got %0d want 1", n_txload - tl0); else pass++;
    chk++; if (bus.busy !== 1'b1) $display("FAIL m0_busy: got %b want 1", bus.busy); else pass++;
    chk++; if (bus.spi_miso_oe !== 1'b1) $display("FAIL m0_oe: got %b want 1", bus.spi_miso_oe); else pass++;
    spi_bits(1'b0, 1'b0, 8, 32'h3C, m);
    frame_finish();
    chk++; if (m[7:0] !== 8'hA5) $display("FAIL m0_miso: got %h want a5", m[7:0]); else pass++;
    chk++; if (bus.rx_data !== 8'h3C) $display("FAIL m0_rx_data: got %h want 3c", bus.rx_data); else pass++;
    chk++; if (n_rxv - rxv0 !== 1) $display("FAIL m0_rx_valid_cnt: got %0d want 1", n_rxv - rxv0); else pass++;
    chk++; if (n_txload - tl0 !== 2) $display("FAIL m0_tx_load_cnt: got %0d want 2", n_txload - tl0); else pass++;
    chk++; if (n_samp - s0 !== 8) $display("FAIL m0_sample_cnt: got %0d want 8", n_samp - s0); else pass++;
    chk++; if (n_samp_hi - h0 !== 8) $display("FAIL m0_sample_edge: got %0d want 8", n_samp_hi - h0); else pass++;
    chk++; if (bus.busy !== 1'b0) $display("FAIL m0_busy_end: got %b want 0", bus.busy); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] m;
    int rxv0 = n_rxv, tl0 = n_txload, s0 = n_samp, h0 = n_samp_hi;
    bus.tx_data = 8'hF0;
    frame_begin(1'b1, 1'b1);
    fork
      spi_bits(1'b1, 1'b1, 16, 32'h817E, m);
      begin : upd
        int  t    = 0;
        bit  seen = 1'b0;
        while (!seen && t < 200) begin
          @(negedge clk);
          t++;
          if (bus.tx_load === 1'b1) seen = 1'b1;
        end
        chk++; if (!seen) $display("FAIL m3_tx_load_wait: got none want pulse"); else pass++;
        bus.tx_data = 8'h0F;
      end
    join
    frame_finish();
    chk++; if (m[15:0] !== 16'hF00F) $display("FAIL m3_miso: got %h want f00f", m[15:0]); else pass++;
    chk++; if (n_rxv - rxv0 !== 2) $display("FAIL m3_rx_valid_cnt: got %0d want 2", n_rxv - rxv0); else pass++;
    chk++; if (rx_hist[rxv0 % 64] !== 8'h81) $display("FAIL m3_word0: got %h want 81", rx_hist[rxv0 % 64]); else pass++;
    chk++; if (rx_hist[(rxv0 + 1) % 64] !== 8'h7E) $display("FAIL m3_word1: got %h want 7e", rx_hist[(rxv0 + 1) % 64]); else pass++;
    chk++; if (n_txload - tl0 !== 2) $display("FAIL m3_tx_load_cnt: got %0d want 2", n_txload - tl0); else pass++;
    chk++; if (n_samp - s0 !== 16) $display("FAIL m3_sample_cnt: got %0d want 16", n_samp - s0); else pass++;
    chk++; if (n_samp_hi - h0 !== 16) $display("FAIL m3_sample_edge: got %0d want 16", n_samp_hi - h0); else pass++;
  endtask

  task automatic test_modes_1_2();
    logic [31:0] m;
    for (int md = 1; md <= 2; md++) begin
      logic pol = (md == 2);
      logic pha = (md == 1);
      int rxv0 = n_rxv, s0 = n_samp, h0 = n_samp_hi;
      bus.tx_data = 8'h3C;
      frame_begin(pol, pha);
      spi_bits(pol, pha, 8, 32'h55, m);
      frame_finish();
      chk++; if (bus.rx_data !== 8'h55) $display("FAIL mode%0d_rx_data: got %h want 55", md, bus.rx_data); else pass++;
      chk++; if (m[7:0] !== 8'h3C) $display("FAIL mode%0d_miso: got %h want 3c", md, m[7:0]); else pass++;
      chk++; if (n_rxv - rxv0 !== 1) $display("FAIL mode%0d_rx_valid_cnt: got %0d want 1", md, n_rxv - rxv0); else pass++;
      chk++; if (n_samp - s0 !== 8) $display("FAIL mode%0d_sample_cnt: got %0d want 8", md, n_samp - s0); else pass++;
      chk++; if (n_samp_hi - h0 !== 0) $display("FAIL mode%0d_sample_edge: got %0d want 0", md, n_samp_hi - h0); else pass++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] m;
    int rxv0 = n_rxv, fe0 = n_fe, ab0 = n_abort, fa0 = n_fe_abort;
    frame_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 5, 32'h16, m);
    frame_finish();
    chk++; if (n_fe - fe0 !== 1) $display("FAIL ab_frame_end: got %0d want 1", n_fe - fe0); else pass++;
    chk++; if (n_abort - ab0 !== 1) $display("FAIL ab_rx_abort: got %0d want 1", n_abort - ab0); else pass++;
    chk++; if (n_fe_abort - fa0 !== 1) $display("FAIL ab_coincide: got %0d want 1", n_fe_abort - fa0); else pass++;
    chk++; if (n_rxv - rxv0 !== 0) $display("FAIL ab_rx_valid: got %0d want 0", n_rxv - rxv0); else pass++;
    chk++; if (bus.rx_data !== 8'h55) $display("FAIL ab_rx_data_kept: got %h want 55", bus.rx_data); else pass++;
    ab0 = n_abort;
    frame_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 8, 32'h96, m);
    frame_finish();
    chk++; if (bus.rx_data !== 8'h96) $display("FAIL ab_next_rx_data: got %h want 96", bus.rx_data); else pass++;
    chk++; if (n_abort - ab0 !== 0) $display("FAIL ab_next_no_abort: got %0d want 0", n_abort - ab0); else pass++;
  endtask

  task automatic test_cpol_mid();
    logic [31:0] m;
    int h0 = n_samp_hi, rxv0 = n_rxv;
    frame_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 2, 32'h3, m);
    bus.cpol = 1'b1;
    bus.cpha = 1'b1;
    spi_bits(1'b0, 1'b0, 6, 32'h06, m);
    frame_finish();
    chk++; if (bus.rx_data !== 8'hC6) $display("FAIL cp_rx_data: got %h want c6", bus.rx_data); else pass++;
    chk++; if (n_rxv - rxv0 !== 1) $display("FAIL cp_rx_valid_cnt: got %0d want 1", n_rxv - rxv0); else pass++;
    chk++; if (n_samp_hi - h0 !== 8) $display("FAIL cp_old_mode_edge: got %0d want 8", n_samp_hi - h0); else pass++;
    h0 = n_samp_hi;
    frame_begin(1'b1, 1'b0);
    spi_bits(1'b1, 1'b0, 8, 32'h3A, m);
    frame_finish();
    chk++; if (bus.rx_data !== 8'h3A) $display("FAIL cp_next_rx_data: got %h want 3a", bus.rx_data); else pass++;
    chk++; if (n_samp_hi - h0 !== 0) $display("FAIL cp_new_mode_edge: got %0d want 0", n_samp_hi - h0); else pass++;
  endtask

  task automatic test_rst_mid();
    logic [31:0] m;
    int fe0 = n_fe;
    bus.tx_data = 8'hFF;
    frame_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 3, 32'h7, m);
    wait_clk(2);
    chk++; if (bus.busy !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", bus.busy); else pass++;
    rst = 1'b1;
    bus.spi_csn = 1'b1;
    wait_clk(1);
    chk++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", bus.busy); else pass++;
    chk++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL rm_oe: got %b want 0", bus.spi_miso_oe); else pass++;
    chk++; if (bus.spi_miso !== 1'b0) $display("FAIL rm_miso: got %b want 0", bus.spi_miso); else pass++;
    chk++; if (bus.rx_data !== 8'h00) $display("FAIL rm_rx_data: got %h want 00", bus.rx_data); else pass++;
    chk++; if (bus.frame_end !== 1'b0) $display("FAIL rm_frame_end_pulse: got %b want 0", bus.frame_end); else pass++;
    rst = 1'b0;
    wait_clk(8);
    chk++; if (n_fe - fe0 !== 0) $display("FAIL rm_no_frame_end: got %0d want 0", n_fe - fe0); else pass++;
    chk++; if (bus.busy !== 1'b0) $display("FAIL rm_busy_after: got %b want 0", bus.busy); else pass++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_back_to_back();
    test_modes_1_2();
    test_abort();
    test_cpol_mid();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
